// File: rtl/cve2_rvfi_monitor.sv
// RVFI retirement monitor: registered trace record, retire/trap statistics,
// order-consistency flag and a fence-delimited cycle benchmark.
module cve2_rvfi_monitor #(
  parameter bit          VectorBench = 1'b0,
  parameter logic [31:0] FenceInsn   = 32'h0ff0000f,
  parameter bit          LogEnable   = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] hart_id_i,
  input  logic        rvfi_valid,
  input  logic [63:0] rvfi_order,
  input  logic [31:0] rvfi_insn,
  input  logic        rvfi_trap,
  input  logic        rvfi_halt,
  input  logic        rvfi_intr,
  input  logic [1:0]  rvfi_mode,
  input  logic [1:0]  rvfi_ixl,
  input  logic [4:0]  rvfi_rs1_addr,
  input  logic [4:0]  rvfi_rs2_addr,
  input  logic [4:0]  rvfi_rs3_addr,
  input  logic [31:0] rvfi_rs1_rdata,
  input  logic [31:0] rvfi_rs2_rdata,
  input  logic [31:0] rvfi_rs3_rdata,
  input  logic [4:0]  rvfi_rd_addr,
  input  logic [31:0] rvfi_rd_wdata,
  input  logic [31:0] rvfi_pc_rdata,
  input  logic [31:0] rvfi_pc_wdata,
  input  logic [31:0] rvfi_mem_addr,
  input  logic [3:0]  rvfi_mem_rmask,
  input  logic [3:0]  rvfi_mem_wmask,
  input  logic [31:0] rvfi_mem_rdata,
  input  logic [31:0] rvfi_mem_wdata,
  input  logic        vstore_finished_i,
  input  logic        vec_idle_i,
  output logic        trace_valid_o,
  output logic [31:0] trace_pc_o,
  output logic [31:0] trace_insn_o,
  output logic        trace_rd_we_o,
  output logic [4:0]  trace_rd_addr_o,
  output logic [31:0] trace_rd_wdata_o,
  output logic [3:0]  trace_mem_rmask_o,
  output logic [3:0]  trace_mem_wmask_o,
  output logic [31:0] trace_mem_addr_o,
  output logic        trace_trap_o,
  output logic [63:0] retired_cnt_o,
  output logic [31:0] trap_cnt_o,
  output logic        order_err_o,
  output logic [1:0]  bench_state_o,
  output logic [31:0] bench_count_o,
  output logic        bench_done_o
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    RUNNING     = 2'd1,
    WAIT_VSTORE = 2'd2,
    DONE        = 2'd3
  } bench_state_e;

  bench_state_e state_reg;
  logic [63:0]  last_order_reg;
  logic         seen_reg;

  logic rd_we;
  logic fence_event;
  logic drain;

  assign rd_we       = !rvfi_trap && (rvfi_rd_addr != 5'd0);
  assign fence_event = rvfi_valid && (rvfi_insn == FenceInsn) && !rvfi_trap;
  assign drain       = vstore_finished_i && vec_idle_i;

  // Text logging belongs to the simulation harness; these inputs only
  // exist so the monitor drops in beside the core's RVFI port unchanged.
  logic unused;
  assign unused = ^{hart_id_i, rvfi_halt, rvfi_intr, rvfi_mode, rvfi_ixl,
                    rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs3_addr,
                    rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rs3_rdata,
                    rvfi_pc_wdata, rvfi_mem_rdata, rvfi_mem_wdata, LogEnable};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trace_valid_o     <= 1'b0;
      trace_pc_o        <= '0;
      trace_insn_o      <= '0;
      trace_rd_we_o     <= 1'b0;
      trace_rd_addr_o   <= '0;
      trace_rd_wdata_o  <= '0;
      trace_mem_rmask_o <= '0;
      trace_mem_wmask_o <= '0;
      trace_mem_addr_o  <= '0;
      trace_trap_o      <= 1'b0;
    end else begin
      trace_valid_o <= rvfi_valid;
      if (rvfi_valid) begin
        trace_pc_o        <= rvfi_pc_rdata;
        trace_insn_o      <= rvfi_insn;
        trace_rd_we_o     <= rd_we;
        trace_rd_addr_o   <= rvfi_rd_addr;
        trace_rd_wdata_o  <= rd_we ? rvfi_rd_wdata : 32'd0;
        trace_mem_rmask_o <= rvfi_mem_rmask;
        trace_mem_wmask_o <= rvfi_mem_wmask;
        trace_mem_addr_o  <= rvfi_mem_addr;
        trace_trap_o      <= rvfi_trap;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      retired_cnt_o  <= '0;
      trap_cnt_o     <= '0;
      order_err_o    <= 1'b0;
      last_order_reg <= '0;
      seen_reg       <= 1'b0;
    end else if (rvfi_valid) begin
      retired_cnt_o <= retired_cnt_o + 64'd1;
      if (rvfi_trap) begin
        trap_cnt_o <= trap_cnt_o + 32'd1;
      end
      // The first retirement after reset has no predecessor to compare to.
      if (seen_reg && (rvfi_order != last_order_reg + 64'd1)) begin
        order_err_o <= 1'b1;
      end
      last_order_reg <= rvfi_order;
      seen_reg       <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      bench_count_o <= '0;
      bench_done_o  <= 1'b0;
    end else begin
      bench_done_o <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (fence_event) begin
            state_reg     <= RUNNING;
            bench_count_o <= '0;
          end
        end
        RUNNING: begin
          bench_count_o <= bench_count_o + 32'd1;
          if (fence_event) begin
            state_reg    <= VectorBench ? WAIT_VSTORE : DONE;
            bench_done_o <= !VectorBench;
          end
        end
        WAIT_VSTORE: begin
          // Fences retired while draining are deliberately ignored.
          bench_count_o <= bench_count_o + 32'd1;
          if (drain) begin
            state_reg    <= DONE;
            bench_done_o <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bench_state_o = state_reg;

endmodule

// File: tb/tb_cve2_rvfi_monitor.sv
// Directed bench for cve2_rvfi_monitor: instance 0 runs VectorBench=0,
// instance 1 VectorBench=1, both checked every cycle against a bench model.
module tb_cve2_rvfi_monitor;

  localparam logic [31:0] FENCE = 32'h0ff0000f;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] hart_id_i = 32'h0000_0003;
  logic        rvfi_valid;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_insn;
  logic        rvfi_trap, rvfi_halt, rvfi_intr;
  logic [1:0]  rvfi_mode, rvfi_ixl;
  logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs3_addr;
  logic [31:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rs3_rdata;
  logic [4:0]  rvfi_rd_addr;
  logic [31:0] rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata;
  logic [31:0] rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
  logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;
  logic        vstore_finished_i, vec_idle_i;

  logic        t_valid [2];
  logic [31:0] t_pc [2];
  logic [31:0] t_insn [2];
  logic        t_we [2];
  logic [4:0]  t_rd [2];
  logic [31:0] t_wd [2];
  logic [3:0]  t_rm [2];
  logic [3:0]  t_wm [2];
  logic [31:0] t_addr [2];
  logic        t_trap [2];
  logic [63:0] ret_cnt [2];
  logic [31:0] trap_cnt [2];
  logic        ord_err [2];
  logic [1:0]  st [2];
  logic [31:0] cnt [2];
  logic        dn [2];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    cve2_rvfi_monitor #(
      .VectorBench(gi == 1),
      .FenceInsn  (FENCE),
      .LogEnable  (1'b1)
    ) dut (
      .clk_i(clk), .rst_i(rst_i), .hart_id_i(hart_id_i),
      .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
      .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr),
      .rvfi_mode(rvfi_mode), .rvfi_ixl(rvfi_ixl),
      .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rs3_addr(rvfi_rs3_addr),
      .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata), .rvfi_rs3_rdata(rvfi_rs3_rdata),
      .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
      .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
      .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
      .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata),
      .vstore_finished_i(vstore_finished_i), .vec_idle_i(vec_idle_i),
      .trace_valid_o(t_valid[gi]), .trace_pc_o(t_pc[gi]), .trace_insn_o(t_insn[gi]),
      .trace_rd_we_o(t_we[gi]), .trace_rd_addr_o(t_rd[gi]), .trace_rd_wdata_o(t_wd[gi]),
      .trace_mem_rmask_o(t_rm[gi]), .trace_mem_wmask_o(t_wm[gi]), .trace_mem_addr_o(t_addr[gi]),
      .trace_trap_o(t_trap[gi]), .retired_cnt_o(ret_cnt[gi]), .trap_cnt_o(trap_cnt[gi]),
      .order_err_o(ord_err[gi]), .bench_state_o(st[gi]), .bench_count_o(cnt[gi]),
      .bench_done_o(dn[gi])
    );
  end

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Model of what the outputs must show after the current edge.
  logic        e_valid, e_we, e_trap, e_err;
  logic [31:0] e_pc, e_insn, e_wd, e_addr, e_trapc;
  logic [4:0]  e_rd;
  logic [3:0]  e_rm, e_wm;
  logic [63:0] e_ret, last_ord;
  bit          seen;
  int          m_state [2];
  int          m_start [2];
  logic [31:0] m_count [2];
  logic        e_done [2];
  logic [63:0] ord;

  task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s[%0d] at cycle %0d: got %0h, expected %0h", name, inst, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    bit fence, drain;
    if (rst_i) begin
      e_valid = 0; e_pc = 0; e_insn = 0; e_we = 0; e_rd = 0; e_wd = 0;
      e_rm = 0; e_wm = 0; e_addr = 0; e_trap = 0;
      e_ret = 0; e_trapc = 0; e_err = 0; last_ord = 0; seen = 0;
      for (int i = 0; i < 2; i++) begin
        m_state[i] = 0; m_count[i] = 0; m_start[i] = 0; e_done[i] = 0;
      end
      return;
    end
    e_valid = rvfi_valid;
    if (rvfi_valid) begin
      e_pc = rvfi_pc_rdata; e_insn = rvfi_insn; e_rd = rvfi_rd_addr;
      e_we = !rvfi_trap && rvfi_rd_addr != 0;
      e_wd = e_we ? rvfi_rd_wdata : 32'd0;
      e_rm = rvfi_mem_rmask; e_wm = rvfi_mem_wmask; e_addr = rvfi_mem_addr;
      e_trap = rvfi_trap;
      e_ret = e_ret + 1;
      if (rvfi_trap) e_trapc = e_trapc + 1;
      if (seen && rvfi_order != last_ord + 1) e_err = 1;
      last_ord = rvfi_order;
      seen = 1;
    end
    fence = rvfi_valid && rvfi_insn == FENCE && !rvfi_trap;
    drain = vstore_finished_i && vec_idle_i;
    for (int i = 0; i < 2; i++) begin
      case (m_state[i])
        0: if (fence) begin m_state[i] = 1; m_start[i] = cyc; m_count[i] = 0; end
        1: begin
          m_count[i] = 32'(cyc - m_start[i]);
          if (fence) m_state[i] = (i == 1) ? 2 : 3;
        end
        2: begin
          m_count[i] = 32'(cyc - m_start[i]);
          if (drain) m_state[i] = 3;
        end
        default: m_state[i] = 0;
      endcase
      e_done[i] = (m_state[i] == 3);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] insn, input logic [4:0] rd,
                        input logic [31:0] wd, input logic trap);
    rvfi_valid = 1; rvfi_order = ord; rvfi_pc_rdata = pc; rvfi_pc_wdata = pc + 4;
    rvfi_insn = insn; rvfi_rd_addr = rd; rvfi_rd_wdata = wd; rvfi_trap = trap;
    rvfi_mem_addr = pc ^ 32'h0000_1000; rvfi_mem_rmask = pc[5:2]; rvfi_mem_wmask = ~pc[5:2];
    rvfi_rs1_addr = rd + 5'd1; rvfi_rs1_rdata = wd ^ 32'h55;
    $display("retire order=%0d pc=%h insn=%h rd=%0d wd=%h trap=%0b", ord, pc, insn, rd, wd, trap);
    ord = ord + 1;
    tick();
  endtask

  task automatic idle(input int n);
    rvfi_valid = 0;
    rvfi_insn = 32'h0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    rst_i = 1;
    rvfi_valid = 0;
    tick();
    tick();
    rst_i = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk("trace_valid", i, t_valid[i], e_valid);
        chk("trace_pc", i, t_pc[i], e_pc);
        chk("trace_insn", i, t_insn[i], e_insn);
        chk("trace_rd_we", i, t_we[i], e_we);
        chk("trace_rd_addr", i, t_rd[i], e_rd);
        chk("trace_rd_wdata", i, t_wd[i], e_wd);
        chk("trace_mem_rmask", i, t_rm[i], e_rm);
        chk("trace_mem_wmask", i, t_wm[i], e_wm);
        chk("trace_mem_addr", i, t_addr[i], e_addr);
        chk("trace_trap", i, t_trap[i], e_trap);
        chk("retired_cnt", i, ret_cnt[i], e_ret);
        chk("trap_cnt", i, trap_cnt[i], e_trapc);
        chk("order_err", i, ord_err[i], e_err);
        chk("bench_state", i, st[i], m_state[i]);
        chk("bench_count", i, cnt[i], m_count[i]);
        chk("bench_done", i, dn[i], e_done[i]);
      end
    end
  end

  initial begin
    rst_i = 1; rvfi_valid = 0; rvfi_order = 0; rvfi_insn = 0; rvfi_trap = 0;
    rvfi_halt = 0; rvfi_intr = 0; rvfi_mode = 2'b11; rvfi_ixl = 2'b01;
    rvfi_rs1_addr = 0; rvfi_rs2_addr = 0; rvfi_rs3_addr = 0;
    rvfi_rs1_rdata = 0; rvfi_rs2_rdata = 0; rvfi_rs3_rdata = 0;
    rvfi_rd_addr = 0; rvfi_rd_wdata = 0; rvfi_pc_rdata = 0; rvfi_pc_wdata = 0;
    rvfi_mem_addr = 0; rvfi_mem_rmask = 0; rvfi_mem_wmask = 0;
    rvfi_mem_rdata = 0; rvfi_mem_wdata = 0;
    vstore_finished_i = 0; vec_idle_i = 0;

    do_reset();
    chk_en = 1;
    chk("reset_retired", 0, ret_cnt[0], 64'd0);
    chk("reset_state", 1, st[1], 64'd0);

    // Five back-to-back retirements, orders 1..5.
    ord = 1;
    for (int k = 0; k < 5; k++) retire(32'h8000_0000 + 32'(4 * k), 32'h0000_0013, 5'd1, 32'(k), 1'b0);
    idle(1);
    chk("five_retired", 0, ret_cnt[0], 64'd5);
    chk("five_order_ok", 0, ord_err[0], 64'd0);

    // rd=0 never counts as a GPR write; rd=5 does.
    retire(32'h8000_0100, 32'h0000_0033, 5'd0, 32'hDEAD, 1'b0);
    chk("rd0_we", 0, t_we[0], 64'd0);
    chk("rd0_wdata", 0, t_wd[0], 64'd0);
    retire(32'h8000_0104, 32'h0000_0033, 5'd5, 32'hDEAD, 1'b0);
    chk("rd5_we", 0, t_we[0], 64'd1);
    chk("rd5_wdata", 0, t_wd[0], 64'hDEAD);

    // Orders 7 (just retired), 8, then 10.
    retire(32'h8000_0108, 32'h0000_0013, 5'd2, 32'h1, 1'b0);
    chk("order8_ok", 0, ord_err[0], 64'd0);
    ord = 10;
    retire(32'h8000_010c, 32'h0000_0013, 5'd2, 32'h2, 1'b0);
    chk("order10_err", 0, ord_err[0], 64'd1);
    retire(32'h8000_0110, 32'h0000_0073, 5'd3, 32'h3, 1'b1);
    chk("trap_cnt", 0, trap_cnt[0], 64'd1);
    chk("trap_no_we", 0, t_we[0], 64'd0);
    idle(3);
    chk("order_err_sticky", 0, ord_err[0], 64'd1);
    do_reset();
    chk("err_cleared", 0, ord_err[0], 64'd0);

    // Non-vector benchmark: fences 100 cycles apart.
    ord = 1;
    idle(2);
    retire(32'h8000_0200, FENCE, 5'd0, 32'h0, 1'b0);
    chk("bench_running", 0, st[0], 64'd1);
    idle(99);
    retire(32'h8000_0204, FENCE, 5'd0, 32'h0, 1'b0);
    chk("bench100_state", 0, st[0], 64'd3);
    chk("bench100_count", 0, cnt[0], 64'd100);
    chk("bench100_done", 0, dn[0], 64'd1);
    chk("bench100_wait", 1, st[1], 64'd2);
    idle(1);
    chk("bench100_idle", 0, st[0], 64'd0);
    chk("bench100_hold", 0, cnt[0], 64'd100);
    vstore_finished_i = 1; vec_idle_i = 1;
    idle(1);
    chk("vb_drain_done", 1, st[1], 64'd3);
    vstore_finished_i = 0;
    idle(2);

    // Vector benchmark: fences 40 apart, drain 20 cycles after the second.
    retire(32'h8000_0300, FENCE, 5'd0, 32'h0, 1'b0);
    idle(39);
    retire(32'h8000_0304, FENCE, 5'd0, 32'h0, 1'b0);
    chk("nv40_count", 0, cnt[0], 64'd40);
    chk("vb_wait", 1, st[1], 64'd2);
    idle(19);
    chk("vb_still_wait", 1, st[1], 64'd2);
    vstore_finished_i = 1;
    idle(1);
    chk("vb60_state", 1, st[1], 64'd3);
    chk("vb60_count", 1, cnt[1], 64'd60);
    chk("vb60_done", 1, dn[1], 64'd1);
    vstore_finished_i = 0;
    idle(2);

    // Fence and drain in the same WAIT_VSTORE cycle: drain wins.
    retire(32'h8000_0400, FENCE, 5'd0, 32'h0, 1'b0);
    idle(3);
    retire(32'h8000_0404, FENCE, 5'd0, 32'h0, 1'b0);
    idle(2);
    vstore_finished_i = 1;
    retire(32'h8000_0408, FENCE, 5'd0, 32'h0, 1'b0);
    chk("fence_drain_done", 1, st[1], 64'd3);
    vstore_finished_i = 0;
    idle(2);

    // Reset while instance 1 is running.
    retire(32'h8000_0500, FENCE, 5'd0, 32'h0, 1'b0);
    idle(4);
    chk("pre_rst_running", 1, st[1], 64'd1);
    rst_i = 1;
    tick();
    chk("rst_state", 1, st[1], 64'd0);
    chk("rst_count", 1, cnt[1], 64'd0);
    chk("rst_retired", 1, ret_cnt[1], 64'd0);
    chk("rst_no_done", 1, dn[1], 64'd0);
    rst_i = 0;
    idle(3);

    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
